// File: rtl/hs32_mem_resp.sv
// HS32 memory-side responder: word RAM behind a req/ready handshake with WAIT wait states.
// Optional bad-access reporting on the fault port is built when HS32_MEM_FAULT_EN is defined.
module hs32_mem_resp #(
    parameter int AW   = 10,
    parameter int WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] dtwm,
    output logic [31:0] dtrm,
    input  logic        reqm,
    input  logic        rw_mem,
    output logic        rdym
`ifdef HS32_MEM_FAULT_EN
    ,
    output logic        fault
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT - 1);

    state_t         state_r;
    state_t         state_nxt_s;
    logic [3:0]     cnt_r;
    logic [3:0]     cnt_nxt_s;
    logic           ack_go_s;

    logic [AW-1:0]  idx_r;
    logic [31:0]    wdata_r;
    logic           rw_r;

    logic [AW-1:0]  acc_idx_s;
    logic [31:0]    acc_data_s;
    logic           acc_rw_s;
    logic           acc_bad_s;

    logic           rdym_r;
    logic [31:0]    dtrm_r;
    logic [31:0]    mem_r [0:(1 << AW) - 1];

`ifdef HS32_MEM_FAULT_EN
    logic           bad_r;
    logic           fault_r;

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
    endfunction
`else
    logic           addr_unused_s;
    assign addr_unused_s = ^{addr[31:AW+2], addr[1:0]};
`endif

    // With zero wait states ACK is entered at the capture edge, so the live bus is used directly.
    always_comb begin
        acc_idx_s  = idx_r;
        acc_data_s = wdata_r;
        acc_rw_s   = rw_r;
        acc_bad_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            acc_idx_s  = addr[AW+1:2];
            acc_data_s = dtwm;
            acc_rw_s   = rw_mem;
`ifdef HS32_MEM_FAULT_EN
            acc_bad_s  = bad_addr(addr);
`endif
        end else begin
`ifdef HS32_MEM_FAULT_EN
            acc_bad_s  = bad_r;
`endif
        end
    end

    // Next-state and wait counter logic; ack_go_s marks the edge that enters ACK.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ack_go_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (reqm) begin
                    if (WAIT == 32'sd0) begin
                        state_nxt_s = ST_ACK;
                        ack_go_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = WAIT_LD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_ACK;
                    ack_go_s    = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r - 4'd1;
                end
            end
            ST_ACK: begin
                if (reqm) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (reqm) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and request capture registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            idx_r   <= '0;
            wdata_r <= 32'd0;
            rw_r    <= 1'b0;
`ifdef HS32_MEM_FAULT_EN
            bad_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if ((state_r == ST_IDLE) && reqm) begin
                idx_r   <= addr[AW+1:2];
                wdata_r <= dtwm;
                rw_r    <= rw_mem;
`ifdef HS32_MEM_FAULT_EN
                bad_r   <= bad_addr(addr);
`endif
            end
        end
    end

    // Registered handshake outputs; dtrm only changes on a completing read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdym_r  <= 1'b0;
            dtrm_r  <= 32'd0;
`ifdef HS32_MEM_FAULT_EN
            fault_r <= 1'b0;
`endif
        end else begin
            rdym_r  <= ack_go_s;
`ifdef HS32_MEM_FAULT_EN
            fault_r <= ack_go_s & acc_bad_s;
`endif
            if (ack_go_s && !acc_rw_s) begin
                dtrm_r <= acc_bad_s ? 32'd0 : mem_r[acc_idx_s];
            end
        end
    end

    // RAM write port; contents survive reset, but no write lands while reset is held.
    always_ff @(posedge clk) begin
        if (reset && ack_go_s && acc_rw_s && !acc_bad_s) begin
            mem_r[acc_idx_s] <= acc_data_s;
        end
    end

    assign rdym = rdym_r;
    assign dtrm = dtrm_r;
`ifdef HS32_MEM_FAULT_EN
    assign fault = fault_r;
`endif

endmodule

// File: tb/tb_hs32_mem_resp.sv
// Self-checking bench for hs32_mem_resp: instance 0 has WAIT=0, instance 1 has WAIT=1, both AW=10.
module tb_hs32_mem_resp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a [2];
    logic [31:0] addr_a  [2];
    logic [31:0] dtwm_a  [2];
    logic [31:0] dtrm_a  [2];
    logic        reqm_a  [2];
    logic        rw_a    [2];
    logic        rdym_a  [2];
    logic        fault_a [2];

    int          tests = 0;
    int          fails = 0;
    logic [31:0] ref_mem [2][1024];
    logic [31:0] exp_q [$];

    hs32_mem_resp #(.AW(10), .WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset_a[0]), .addr(addr_a[0]), .dtwm(dtwm_a[0]),
        .dtrm(dtrm_a[0]), .reqm(reqm_a[0]), .rw_mem(rw_a[0]), .rdym(rdym_a[0])
`ifdef HS32_MEM_FAULT_EN
        , .fault(fault_a[0])
`endif
    );

    hs32_mem_resp #(.AW(10), .WAIT(1)) u_dut1 (
        .clk(clk), .reset(reset_a[1]), .addr(addr_a[1]), .dtwm(dtwm_a[1]),
        .dtrm(dtrm_a[1]), .reqm(reqm_a[1]), .rw_mem(rw_a[1]), .rdym(rdym_a[1])
`ifdef HS32_MEM_FAULT_EN
        , .fault(fault_a[1])
`endif
    );

`ifndef HS32_MEM_FAULT_EN
    assign fault_a[0] = 1'b0;
    assign fault_a[1] = 1'b0;
`endif

    function automatic logic model_fault(input logic [31:0] a);
`ifdef HS32_MEM_FAULT_EN
        return (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
`else
        return 1'b0;
`endif
    endfunction

    // One complete transfer on instance d; expected read data goes through the scoreboard queue.
    task automatic xfer(input int d, input logic rw, input logic [31:0] a, input logic [31:0] wd);
        int          lat;
        logic        exp_f;
        logic [9:0]  idx;
        logic [31:0] exp_d;
        exp_f = model_fault(a);
        idx   = a[11:2];
        exp_d = 32'd0;
        if (!rw) begin
            exp_q.push_back(exp_f ? 32'd0 : ref_mem[d][idx]);
        end else if (!exp_f) begin
            ref_mem[d][idx] = wd;
        end
        addr_a[d] = a;
        dtwm_a[d] = wd;
        rw_a[d]   = rw;
        reqm_a[d] = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rdym_a[d] && lat < 20);
        reqm_a[d] = 1'b0;
        tests++;
        if (rdym_a[d] !== 1'b1) begin
            fails++;
            $display("FAIL xfer_timeout inst=%0d addr=%h: rdym=%b after %0d cycles, required 1", d, a, rdym_a[d], lat);
        end else if (lat !== 1 + d) begin
            fails++;
            $display("FAIL latency inst=%0d addr=%h: got %0d, required %0d", d, a, lat, 1 + d);
        end
`ifdef HS32_MEM_FAULT_EN
        tests++;
        if (fault_a[d] !== exp_f) begin
            fails++;
            $display("FAIL fault_flag inst=%0d addr=%h: got %b, required %b", d, a, fault_a[d], exp_f);
        end
`endif
        if (!rw) begin
            exp_d = exp_q.pop_front();
            tests++;
            if (dtrm_a[d] !== exp_d) begin
                fails++;
                $display("FAIL read_data inst=%0d addr=%h: got %h, required %h", d, a, dtrm_a[d], exp_d);
            end
        end
        @(posedge clk); #1;
        tests++;
        if (rdym_a[d] !== 1'b0 || fault_a[d] !== 1'b0) begin
            fails++;
            $display("FAIL pulse_width inst=%0d addr=%h: rdym=%b fault=%b, required 0/0", d, a, rdym_a[d], fault_a[d]);
        end
        if (!rw) begin
            tests++;
            if (dtrm_a[d] !== exp_d) begin
                fails++;
                $display("FAIL read_hold inst=%0d addr=%h: got %h, required %h", d, a, dtrm_a[d], exp_d);
            end
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            reset_a[d] = 1'b0; reqm_a[d] = 1'b0; rw_a[d] = 1'b0;
            addr_a[d] = 32'd0; dtwm_a[d] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (rdym_a[d] !== 1'b0 || dtrm_a[d] !== 32'd0 || fault_a[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_state inst=%0d: rdym=%b dtrm=%h fault=%b, required 0/0/0", d, rdym_a[d], dtrm_a[d], fault_a[d]);
            end
            reset_a[d] = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        xfer(1, 1'b1, 32'h10, 32'hCAFE_F00D);
        xfer(1, 1'b0, 32'h10, 32'd0);
    endtask

    task automatic test_back_to_back();
        xfer(0, 1'b1, 32'h0, 32'h0101_0101);
        xfer(0, 1'b1, 32'h4, 32'h2222_3333);
        xfer(0, 1'b1, 32'h8, 32'hF0E1_D2C3);
        xfer(0, 1'b0, 32'h0, 32'd0);
        xfer(0, 1'b0, 32'h4, 32'd0);
        xfer(0, 1'b0, 32'h8, 32'd0);
    endtask

    task automatic test_held_reqm();
        int pulses;
        int lat;
        addr_a[0] = 32'h40; dtwm_a[0] = 32'h600D_D00D; rw_a[0] = 1'b1; reqm_a[0] = 1'b1;
        ref_mem[0][10'h10] = 32'h600D_D00D;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rdym_a[0] && lat < 20);
        tests++;
        if (rdym_a[0] !== 1'b1) begin
            fails++;
            $display("FAIL held_first_rdym: rdym=%b, required 1", rdym_a[0]);
        end
        dtwm_a[0] = 32'hDEAD_BEEF;
        pulses = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rdym_a[0]) pulses++;
        end
        tests++;
        if (pulses !== 0) begin
            fails++;
            $display("FAIL held_extra_rdym: got %0d pulses, required 0", pulses);
        end
        reqm_a[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        xfer(0, 1'b0, 32'h40, 32'd0);
    endtask

    task automatic test_reset_mid_write();
        xfer(1, 1'b1, 32'h20, 32'h1111_1111);
        xfer(1, 1'b0, 32'h20, 32'd0);
        addr_a[1] = 32'h20; dtwm_a[1] = 32'h1234_5678; rw_a[1] = 1'b1; reqm_a[1] = 1'b1;
        @(posedge clk); #1;
        reset_a[1] = 1'b0;
        #1;
        tests++;
        if (rdym_a[1] !== 1'b0 || dtrm_a[1] !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid_write: rdym=%b dtrm=%h, required 0/00000000", rdym_a[1], dtrm_a[1]);
        end
        reqm_a[1] = 1'b0;
        @(posedge clk); #1;
        reset_a[1] = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'h20, 32'd0);
    endtask

`ifdef HS32_MEM_FAULT_EN
    task automatic test_fault();
        xfer(1, 1'b1, 32'h0, 32'h0BAD_F00D);
        xfer(1, 1'b1, 32'h1000, 32'h7777_7777);
        xfer(1, 1'b0, 32'h0, 32'd0);
        xfer(1, 1'b0, 32'h2, 32'd0);
    endtask
`else
    task automatic test_alias();
        xfer(1, 1'b1, 32'h1000, 32'hA5A5_A5A5);
        xfer(1, 1'b0, 32'h0, 32'd0);
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_held_reqm();
        test_reset_mid_write();
`ifdef HS32_MEM_FAULT_EN
        test_fault();
`else
        test_alias();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
